// File: rtl/adj_stream_pkg.sv
// Shared definitions for the adjacency-list streamer: FSM state codes, config
// target select codes and the width helper used to size the config port.
package adj_stream_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_END    = 3'd2;
  localparam state_t ST_LOOKUP = 3'd3;
  localparam state_t ST_STREAM = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam logic [1:0] CFG_SEL_OFFSET = 2'd0;
  localparam logic [1:0] CFG_SEL_EDGE   = 2'd1;
  localparam logic [1:0] CFG_SEL_START  = 2'd2;
  localparam logic [1:0] CFG_SEL_END    = 2'd3;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adj_ram.sv
// Simple table storage: synchronous write, asynchronous (combinational) read.
// Contents are never reset so a loaded graph survives rst.
module adj_ram
  import adj_stream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adj_list_streamer.sv
// CSR graph store that presents start/end nodes, then streams the successors of
// each node the path-count engine requests, one edge per cycle with a down-counter.
module adj_list_streamer
  import adj_stream_pkg::*;
#(
  parameter int NODE_IDX_WIDTH  = 10,
  parameter int COUNTER_WIDTH   = 4,
  parameter int EDGE_ADDR_WIDTH = 11,
  parameter logic [NODE_IDX_WIDTH-1:0] NULL_NODE_IDX = '1,
  localparam int CFG_ADDR_W = max_w(NODE_IDX_WIDTH, EDGE_ADDR_WIDTH),
  localparam int CFG_DATA_W = EDGE_ADDR_WIDTH + COUNTER_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_run,
  input  logic                      cfg_wr_en,
  input  logic [1:0]                cfg_sel,
  input  logic [CFG_ADDR_W-1:0]     cfg_addr,
  input  logic [CFG_DATA_W-1:0]     cfg_wdata,
  input  logic [NODE_IDX_WIDTH-1:0] node_idx,
  input  logic                      rd_next_node,
  input  logic                      done,
  output logic [NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [COUNTER_WIDTH-1:0]  next_node_counter,
  output logic                      err_zero_degree,
  output logic                      err_cfg_busy
);

  logic                       cfg_ok;
  logic [NODE_IDX_WIDTH-1:0]  start_idx;
  logic [NODE_IDX_WIDTH-1:0]  end_idx;
  state_t                     state;
  logic [EDGE_ADDR_WIDTH-1:0] ptr;
  logic [CFG_DATA_W-1:0]      offset_rd;
  logic [EDGE_ADDR_WIDTH-1:0] lkp_base;
  logic [COUNTER_WIDTH-1:0]   lkp_degree;
  logic [EDGE_ADDR_WIDTH-1:0] edge_rd_addr;
  logic [NODE_IDX_WIDTH-1:0]  edge_rd_data;

  // Config writes only land while the engine is idle; otherwise they are dropped.
  assign cfg_ok = cfg_wr_en & ~start_run;

  always_ff @(posedge clk) begin
    if (cfg_ok && cfg_sel == CFG_SEL_START) start_idx <= cfg_wdata[NODE_IDX_WIDTH-1:0];
    if (cfg_ok && cfg_sel == CFG_SEL_END)   end_idx   <= cfg_wdata[NODE_IDX_WIDTH-1:0];
  end

  adj_ram #(
    .WIDTH  (CFG_DATA_W),
    .ADDR_W (NODE_IDX_WIDTH)
  ) u_offset_ram (
    .clk     (clk),
    .wr_en   (cfg_ok && cfg_sel == CFG_SEL_OFFSET),
    .wr_addr (cfg_addr[NODE_IDX_WIDTH-1:0]),
    .wr_data (cfg_wdata),
    .rd_addr (node_idx),
    .rd_data (offset_rd)
  );

  assign lkp_base   = offset_rd[CFG_DATA_W-1:COUNTER_WIDTH];
  assign lkp_degree = offset_rd[COUNTER_WIDTH-1:0];

  // The lookup cycle fetches the first edge straight from base; later edges come from ptr.
  assign edge_rd_addr = (state == ST_LOOKUP) ? lkp_base : ptr;

  adj_ram #(
    .WIDTH  (NODE_IDX_WIDTH),
    .ADDR_W (EDGE_ADDR_WIDTH)
  ) u_edge_ram (
    .clk     (clk),
    .wr_en   (cfg_ok && cfg_sel == CFG_SEL_EDGE),
    .wr_addr (cfg_addr[EDGE_ADDR_WIDTH-1:0]),
    .wr_data (cfg_wdata[NODE_IDX_WIDTH-1:0]),
    .rd_addr (edge_rd_addr),
    .rd_data (edge_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      next_node_idx     <= '0;
      next_node_counter <= '0;
      err_zero_degree   <= 1'b0;
      err_cfg_busy      <= 1'b0;
    end else begin
      if (start_run && cfg_wr_en) err_cfg_busy <= 1'b1;
      if (start_run) begin
        if (done) begin
          state <= ST_DONE;
        end else begin
          case (state)
            ST_IDLE: begin
              next_node_idx     <= start_idx;
              next_node_counter <= '0;
              state             <= ST_START;
            end
            ST_START: begin
              next_node_idx     <= start_idx;
              next_node_counter <= '0;
              state             <= ST_END;
            end
            ST_END: begin
              next_node_idx     <= end_idx;
              next_node_counter <= '0;
              state             <= ST_LOOKUP;
            end
            ST_LOOKUP: begin
              if (rd_next_node) begin
                if (lkp_degree == '0) begin
                  // A sink node still yields one "last" edge so the engine can move on.
                  next_node_idx     <= NULL_NODE_IDX;
                  next_node_counter <= COUNTER_WIDTH'(1);
                  err_zero_degree   <= 1'b1;
                end else begin
                  next_node_idx     <= edge_rd_data;
                  next_node_counter <= lkp_degree;
                  ptr               <= lkp_base + EDGE_ADDR_WIDTH'(1);
                end
                state <= ST_STREAM;
              end
            end
            ST_STREAM: begin
              if (next_node_counter > COUNTER_WIDTH'(1)) begin
                next_node_idx     <= edge_rd_data;
                next_node_counter <= next_node_counter - COUNTER_WIDTH'(1);
                ptr               <= ptr + EDGE_ADDR_WIDTH'(1);
              end else begin
                state <= ST_LOOKUP;
              end
            end
            default: begin
              state <= ST_DONE;
            end
          endcase
        end
      end
    end
  end

endmodule
